dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory access sequencer. It sits downstream of the instruction control generator and the ALU.
- Takes the computed byte address, the store data, memop (func3 encoding) and memwr. Drives a word-wide synchronous single-port RAM that has no byte enables.
- Performs sub-word loads with sign or zero extension. Performs sub-word stores as read-modify-write.
- Returns the load result to the write-back mux with a req/ready/done handshake, so a multi-cycle core can stall on it.

Parameters:
- AW, 15, RAM word-address width. Usable byte address bits are addr[AW+1:0]; higher bits are ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only while ready=1.
- memwr  in  1  1 = store, 0 = load.
- memop  in  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
- addr  in  32  byte address.
- wdata  in  32  store data; low byte or halfword is used for sub-word stores.
- ready  out  1  block is idle and can accept req.
- done  out  1  one-cycle pulse: access complete; rdata and err are valid.
- rdata  out  32  extended load result; held until the next load completes.
- err  out  1  misaligned or illegal access; held until the next acceptance.
- ram_addr  out  AW  RAM word address = addr[AW+1:2] of the latched request.
- ram_rd_en  out  1  RAM read strobe; ram_rdata is valid in the following cycle.
- ram_wr_en  out  1  RAM write strobe; the write is committed at that clock edge.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Reset (asynchronous, active-high, immediate): state=IDLE, rdata=0, err=0, internal address/op/data/merge registers=0. While rst=1: ram_rd_en=0, ram_wr_en=0, done=0, ready=0.
- Reset mid-access aborts the access. No later strobes or done are issued, and no partial write follows.
- Outputs decode from registered state:
  - ready=(state==IDLE).
  - done=(state==RSP).
  - ram_rd_en=(state==RD).
  - ram_wr_en=(state==WR).
- Acceptance: in IDLE with req=1, latch addr, memop, memwr and wdata, and clear err.
- Illegal accesses: an illegal op (load memop 011/110/111; store memop other than 000/001/010) or a misalignment (half with addr[0]=1; word with addr[1:0]!=0) sets err=1 and goes to RSP. No RAM strobe is issued and rdata is unchanged.
- State transitions:
  - IDLE: with req, load or sub-word store goes to RD; word store goes to WR; error goes to RSP. Without req, stay in IDLE.
  - RD: go to MRG.
  - MRG: ram_rdata is valid. For a load, register the extended lane into rdata and go to RSP. For a sub-word store, register the merged word into the write buffer and go to WR.
  - WR: ram_wdata = buffer (word store: latched wdata). Go to RSP.
  - RSP: done=1. Go to IDLE.
- Lane select (little-endian):
  - byte lane = addr[1:0] (byte k = bits 8k+7:8k).
  - half lane = addr[1] (low half = bits 15:0, high half = bits 31:16).
  - Signed ops replicate the lane MSB; unsigned ops zero-fill.
- Merge: replace only the addressed byte/half lane with wdata[7:0] / wdata[15:0]. All other bits keep their ram_rdata value.
- Latency, counted from the acceptance edge to the cycle in which done=1:
  - load: 3 cycles.
  - word store: 2 cycles.
  - sub-word store: 4 cycles.
  - error: 1 cycle.
- Throughput: ready returns the cycle after done, so back-to-back requests space one idle cycle after each done.
- req while ready=0 is ignored; the requester holds req until it sees acceptance.

Test Plan:
- RAM word 4 = 0x8899AABB. lw addr 0x10 -> done 3 cycles after acceptance, rdata=0x8899AABB, err=0, exactly one ram_rd_en with ram_addr=4, no ram_wr_en.
- Same word. lb 0x13 -> rdata 0xFFFFFF88; lbu 0x12 -> 0x00000099; lh 0x12 -> 0xFFFF8899; lhu 0x10 -> 0x0000AABB.
- Same word. sb 0x11 wdata 0x12345677 -> RAM word 4 = 0x889977BB, done 4 cycles after acceptance. Then sh 0x12 wdata 0x0000CAFE -> 0xCAFE77BB. sw 0x10 wdata 0x01020304 -> no ram_rd_en, word = 0x01020304, done 2 cycles after acceptance.
- Illegal accesses:
  - lw 0x12 -> err=1, done 1 cycle after acceptance, no RAM strobes, rdata unchanged.
  - sh 0x13 -> err=1, no write.
  - load memop 111 -> err=1.
  - A subsequent legal lw clears err.
- Assert rst during MRG of sb 0x11 -> state IDLE immediately, ram_wr_en never asserted, RAM word unchanged, rdata=0, err=0. Next lw completes normally.
- Back-to-back: req held high across lw 0x10 then lbu 0x13 -> second acceptance occurs the cycle after the first done, results 0x8899AABB then 0x00000088, and req is ignored while ready=0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory access sequencer: sub-word loads with sign/zero extension and
// read-modify-write sub-word stores on a word-wide RAM that has no byte enables.
module dmem_ctrl #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          memwr,
    input  logic [2:0]    memop,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd_en,
    output logic          ram_wr_en,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] MRG  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RSP  = 3'd4;

    logic [2:0]    state_reg;
    logic [AW+1:0] addr_reg;
    logic [2:0]    op_reg;
    logic          wr_reg;
    logic [31:0]   wbuf_reg;
    logic [31:0]   rdata_reg;
    logic          err_reg;

    logic          op_bad;
    logic          misaligned;
    logic          acc_err;
    logic [31:0]   merged;
    logic [31:0]   load_ext;
    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic          unused_addr_bits;

    // Bits above the RAM's byte range are deliberately ignored.
    assign unused_addr_bits = ^addr[31:AW+2];

    always_comb begin
        if (memwr)
            op_bad = !(memop == 3'b000 || memop == 3'b001 || memop == 3'b010);
        else
            op_bad = (memop == 3'b011) || (memop[2:1] == 2'b11);
        misaligned = ((memop[1:0] == 2'b01) && addr[0]) ||
                     ((memop[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        acc_err    = op_bad || misaligned;
    end

    // Store merge: each byte lane takes store data only when it is addressed.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            logic byte_hit;
            logic half_hit;
            assign byte_hit = (op_reg[1:0] == 2'b00) && (addr_reg[1:0] == 2'(gi));
            assign half_hit = (op_reg[1:0] == 2'b01) && (addr_reg[1] == 1'(gi / 2));
            assign merged[8*gi +: 8] = byte_hit ? wbuf_reg[7:0] :
                                       half_hit ? wbuf_reg[8*(gi % 2) +: 8] :
                                                  ram_rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_lane = ram_rdata[{addr_reg[1:0], 3'b000} +: 8];
    assign half_lane = addr_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        case (op_reg[1:0])
            2'b00:   load_ext = {{24{byte_lane[7] & ~op_reg[2]}}, byte_lane};
            2'b01:   load_ext = {{16{half_lane[15] & ~op_reg[2]}}, half_lane};
            default: load_ext = ram_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            op_reg    <= '0;
            wr_reg    <= 1'b0;
            wbuf_reg  <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        addr_reg <= addr[AW+1:0];
                        op_reg   <= memop;
                        wr_reg   <= memwr;
                        wbuf_reg <= wdata;
                        err_reg  <= acc_err;
                        if (acc_err)
                            state_reg <= RSP;
                        else if (memwr && (memop[1:0] == 2'b10))
                            state_reg <= WR;
                        else
                            state_reg <= RD;
                    end
                end
                RD:  state_reg <= MRG;
                MRG: begin
                    if (wr_reg) begin
                        wbuf_reg  <= merged;
                        state_reg <= WR;
                    end else begin
                        rdata_reg <= load_ext;
                        state_reg <= RSP;
                    end
                end
                WR:      state_reg <= RSP;
                RSP:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // State is already IDLE during reset, so ready needs rst masked in.
    assign ready     = (state_reg == IDLE) && !rst;
    assign done      = (state_reg == RSP);
    assign ram_rd_en = (state_reg == RD);
    assign ram_wr_en = (state_reg == WR);
    assign ram_addr  = addr_reg[AW+1:2];
    assign ram_wdata = wbuf_reg;
    assign rdata     = rdata_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: behavioural synchronous RAM plus
// hand-computed expectations for loads, stores, errors, reset and back-to-back.
module tb_dmem_ctrl;

    localparam int AW = 15;

    logic          clk;
    logic          rst;
    logic          req;
    logic          memwr;
    logic [2:0]    memop;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          ready;
    logic          done;
    logic [31:0]   rdata;
    logic          err;
    logic [AW-1:0] ram_addr;
    logic          ram_rd_en;
    logic          ram_wr_en;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic          bd_we;
    logic [31:0]   bd_val;

    int vectors;
    int miscompares;
    int rd_total;
    int wr_total;
    logic [AW-1:0] last_rd_addr;

    dmem_ctrl #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .memwr(memwr), .memop(memop),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done),
        .rdata(rdata), .err(err), .ram_addr(ram_addr),
        .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model with a backdoor into word 4.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wdata;
        if (ram_rd_en) ram_rdata <= mem[ram_addr];
        if (bd_we) mem[4] <= bd_val;
    end

    initial begin
        rd_total = 0;
        wr_total = 0;
        last_rd_addr = '0;
    end

    always @(negedge clk) begin
        if (ram_rd_en) begin
            rd_total = rd_total + 1;
            last_rd_addr = ram_addr;
        end
        if (ram_wr_en) wr_total = wr_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke4(input logic [31:0] v);
        @(negedge clk);
        bd_we = 1'b1;
        bd_val = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        @(negedge clk);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic access(input logic wr, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req = 1'b1;
        memwr = wr;
        memop = op;
        addr = a;
        wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int rd0;
        int wr0;
        int early;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        req = 1'b0;
        memwr = 1'b0;
        memop = 3'b000;
        addr = '0;
        wdata = '0;
        bd_we = 1'b0;
        bd_val = '0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_strobes", {30'd0, ram_rd_en, ram_wr_en}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        poke4(32'h8899AABB);

        // Word load
        rd0 = rd_total; wr0 = wr_total;
        access(1'b0, 3'b010, 32'h10, 32'h0, lat);
        $display("lw 0x10 -> rdata=%h err=%b lat=%0d", rdata, err, lat);
        chk("lw_lat", lat, 3);
        chk("lw_rdata", rdata, 32'h8899AABB);
        chk("lw_err", {31'd0, err}, 32'd0);
        chk("lw_rd_cnt", rd_total - rd0, 1);
        chk("lw_wr_cnt", wr_total - wr0, 0);
        chk("lw_ram_addr", {17'd0, last_rd_addr}, 32'd4);

        // Sub-word loads
        access(1'b0, 3'b000, 32'h13, 32'h0, lat);
        $display("lb 0x13 -> rdata=%h", rdata);
        chk("lb_13", rdata, 32'hFFFFFF88);
        access(1'b0, 3'b100, 32'h12, 32'h0, lat);
        $display("lbu 0x12 -> rdata=%h", rdata);
        chk("lbu_12", rdata, 32'h00000099);
        access(1'b0, 3'b001, 32'h12, 32'h0, lat);
        $display("lh 0x12 -> rdata=%h", rdata);
        chk("lh_12", rdata, 32'hFFFF8899);
        access(1'b0, 3'b101, 32'h10, 32'h0, lat);
        $display("lhu 0x10 -> rdata=%h", rdata);
        chk("lhu_10", rdata, 32'h0000AABB);

        // Stores
        access(1'b1, 3'b000, 32'h11, 32'h12345677, lat);
        $display("sb 0x11 -> mem4=%h lat=%0d", mem[4], lat);
        chk("sb_lat", lat, 4);
        chk("sb_mem", mem[4], 32'h889977BB);
        access(1'b1, 3'b001, 32'h12, 32'h0000CAFE, lat);
        $display("sh 0x12 -> mem4=%h", mem[4]);
        chk("sh_mem", mem[4], 32'hCAFE77BB);
        rd0 = rd_total;
        access(1'b1, 3'b010, 32'h10, 32'h01020304, lat);
        $display("sw 0x10 -> mem4=%h lat=%0d", mem[4], lat);
        chk("sw_lat", lat, 2);
        chk("sw_rd_cnt", rd_total - rd0, 0);
        chk("sw_mem", mem[4], 32'h01020304);
        chk("store_rdata_kept", rdata, 32'h0000AABB);

        // Illegal accesses
        rd0 = rd_total; wr0 = wr_total;
        access(1'b0, 3'b010, 32'h12, 32'h0, lat);
        $display("lw 0x12 -> err=%b lat=%0d rdata=%h", err, lat, rdata);
        chk("mis_lw_err", {31'd0, err}, 32'd1);
        chk("mis_lw_lat", lat, 1);
        chk("mis_lw_strobes", (rd_total - rd0) + (wr_total - wr0), 0);
        chk("mis_lw_rdata", rdata, 32'h0000AABB);
        wr0 = wr_total;
        access(1'b1, 3'b001, 32'h13, 32'hFFFF, lat);
        $display("sh 0x13 -> err=%b mem4=%h", err, mem[4]);
        chk("mis_sh_err", {31'd0, err}, 32'd1);
        chk("mis_sh_wr_cnt", wr_total - wr0, 0);
        chk("mis_sh_mem", mem[4], 32'h01020304);
        access(1'b0, 3'b111, 32'h10, 32'h0, lat);
        $display("load op111 -> err=%b", err);
        chk("op111_err", {31'd0, err}, 32'd1);
        access(1'b0, 3'b010, 32'h10, 32'h0, lat);
        $display("lw 0x10 after err -> err=%b rdata=%h", err, rdata);
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("clr_rdata", rdata, 32'h01020304);

        // Reset during MRG of a sub-word store
        poke4(32'h8899AABB);
        @(negedge clk);
        wr0 = wr_total;
        req = 1'b1; memwr = 1'b1; memop = 3'b000; addr = 32'h11; wdata = 32'h12345677;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        $display("rst in MRG -> ready=%b wr_en=%b rdata=%h err=%b", ready, ram_wr_en, rdata, err);
        chk("midrst_wr_en", {31'd0, ram_wr_en}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_idle", {31'd0, ready}, 32'd1);
        chk("midrst_no_write", wr_total - wr0, 0);
        chk("midrst_mem", mem[4], 32'h8899AABB);
        access(1'b0, 3'b010, 32'h10, 32'h0, lat);
        $display("lw after reset -> rdata=%h lat=%0d", rdata, lat);
        chk("postrst_lw", rdata, 32'h8899AABB);
        chk("postrst_lat", lat, 3);

        // Back-to-back with req held high
        @(negedge clk);
        rd0 = rd_total;
        req = 1'b1; memwr = 1'b0; memop = 3'b010; addr = 32'h10;
        @(posedge clk);
        #1 memop = 3'b100; addr = 32'h13;
        early = 0;
        lat = 1;
        @(negedge clk);
        while (!done && lat < 20) begin
            if (ready) early++;
            @(negedge clk);
            lat++;
        end
        $display("b2b first -> rdata=%h lat=%0d", rdata, lat);
        chk("b2b1_done", {31'd0, done}, 32'd1);
        chk("b2b1_lat", lat, 3);
        chk("b2b1_rdata", rdata, 32'h8899AABB);
        chk("b2b_busy_ignored", early, 0);
        @(negedge clk);
        chk("b2b_ready_after_done", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1 req = 1'b0;
        wait_done(lat);
        $display("b2b second -> rdata=%h lat=%0d", rdata, lat);
        chk("b2b2_lat", lat, 3);
        chk("b2b2_rdata", rdata, 32'h00000088);
        chk("b2b_rd_cnt", rd_total - rd0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
